trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, value driven on o_redirect_pc while in reset.
REQ-002 clk  in  1  core clock; every flop is clocked on the rising edge.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 exc_valid  in  1  synchronous exception reported by the retiring instruction.
REQ-005 exc_cause  in  31  exception code.
REQ-006 exc_pc  in  32  PC of the faulting instruction.
REQ-007 exc_tval  in  32  trap value for the exception.
REQ-008 mret  in  1  retiring instruction is MRET.
REQ-009 inst_valid  in  1  the retire stage holds a valid instruction.
REQ-010 inst_pc  in  32  PC of the retire-stage instruction.
REQ-011 ext_irq, sw_irq, timer_irq  in  1 each  asynchronous interrupt lines, level-sensitive.
REQ-012 o_mstatus_mie, o_mstatus_mpie  in  1 each  current mstatus bits from the CSR block.
REQ-013 o_mtvec_base  in  30  and  o_mtvec_mode  in  2  are the current mtvec fields.
REQ-014 o_mepc_value  in  32  current mepc.
REQ-015 take_trap  out  1  CSR hardware-update write enable.
REQ-016 i_mcause_interrupt  out  1, i_mcause_exception_code  out  31, i_mepc_value  out  32, i_mtval_value  out  32  are the CSR update values.
REQ-017 i_mstatus_mie, i_mstatus_mpie  out  1 each, i_mstatus_mpp  out  2  are the mstatus update values.
REQ-018 o_redirect  out  1, o_redirect_pc  out  32, o_flush  out  1  form the pipeline control outputs.

Function
REQ-019 Each irq line SHALL pass through a 2-flop synchronizer; only the synchronized copies are used.
REQ-020 FSM states SHALL be IDLE, ENTER and RETURN; ENTER and RETURN SHALL last exactly one cycle and then go to IDLE.
REQ-021 In IDLE, the request priority SHALL be: exc_valid, then a pending interrupt, then mret.
REQ-022 A pending interrupt SHALL require o_mstatus_mie=1, inst_valid=1 and at least one synchronized line high; code priority SHALL be ext (11), then sw (3), then timer (7).
REQ-023 A request sampled in IDLE at cycle N SHALL produce ENTER or RETURN in cycle N+1, with take_trap=1, o_redirect=1 and o_flush=1 in that cycle only.
REQ-024 ENTER capture, latched at cycle N: mcause_interrupt=0 and code=exc_cause for an exception, or mcause_interrupt=1 and code=irq code for an interrupt.
REQ-025 ENTER capture, continued: mepc=exc_pc for an exception, inst_pc for an interrupt; mtval=exc_tval for an exception, 0 for an interrupt.
REQ-026 ENTER mstatus: i_mstatus_mpie=o_mstatus_mie, i_mstatus_mie=0, i_mstatus_mpp=2'b11.
REQ-027 ENTER target: {o_mtvec_base,2'b00}; when mtvec_mode=1 and the trap is an interrupt, the target SHALL instead be {o_mtvec_base,2'b00}+(code<<2), truncated to 32 bits; mode 2 and 3 SHALL behave as direct.
REQ-028 RETURN: i_mstatus_mie=o_mstatus_mpie, i_mstatus_mpie=1, i_mstatus_mpp=2'b11, o_redirect_pc=o_mepc_value.
REQ-029 RETURN write-back: i_mepc_value=o_mepc_value; mcause and mtval outputs SHALL replay the shadow registers holding the values of the last ENTER.
REQ-030 Shadow mcause/mtval SHALL update only in ENTER and SHALL hold otherwise.
REQ-031 All requests SHALL be ignored while in ENTER or RETURN; the pipeline is flushed and retire inputs are invalid.
REQ-032 Outside ENTER and RETURN: take_trap=o_redirect=o_flush=0; update outputs hold their last values.
REQ-033 exc_valid together with mret SHALL be taken as an exception; exc_valid together with an interrupt SHALL take the exception and leave the interrupt pending.

Reset
REQ-034 While rst=0: state=IDLE; synchronizers, shadows and all outputs 0, except o_redirect_pc=RESET_PC.
REQ-035 Reset asserted during ENTER or RETURN SHALL abort that state immediately; no take_trap pulse after release.

Verification
REQ-036 Exception: exc_valid, cause=2, pc=0x100, tval=0xDEAD, mie=1, mtvec=0x8000 -> next cycle take_trap=1, code=2, intr=0, mepc=0x100, mtval=0xDEAD, mpie=1, mie=0, redirect_pc=0x8000.
REQ-037 Vectored interrupt: timer_irq and ext_irq high, mie=1, mode=1, base 0x8000, inst_pc=0x200 -> 3 cycles later ENTER, code=11, intr=1, mepc=0x200, mtval=0, redirect_pc=0x802C.
REQ-038 Masked interrupt: timer_irq high, mie=0 for 10 cycles -> no take_trap; raise mie -> ENTER with code=7.
REQ-039 MRET after REQ-036: mret, mpie=1, mepc=0x104 -> take_trap=1, mie=1, mpie=1, code=2 and mtval=0xDEAD replayed, redirect_pc=0x104.
REQ-040 Collisions: exc_valid+mret together -> ENTER; exc_valid on the cycle right after a request -> ignored; rst=0 asserted during ENTER -> take_trap=0 immediately, redirect_pc=RESET_PC.

Source files
------------

// File: rtl/trap_ctrl.sv
// trap_ctrl -- machine-mode trap sequencer.
//
// Watches the retire stage for synchronous exceptions, MRET and pending
// interrupts, and for each accepted request produces a one-cycle trap
// (ENTER) or return (RETURN) step. That step carries the CSR
// hardware-update values and the pipeline redirect/flush.
//
// Ports
//   clk, rst                  core clock, asynchronous active-low reset
//   exc_valid/cause/pc/tval   exception reported by the retiring instruction
//   mret                      retiring instruction is MRET
//   inst_valid, inst_pc       retire-stage instruction (used for interrupts)
//   ext_irq/sw_irq/timer_irq  asynchronous level-sensitive interrupt lines
//   o_mstatus_*, o_mtvec_*,
//   o_mepc_value              current CSR values read from the CSR block
//   take_trap, i_*            CSR hardware-update strobe and update values
//   o_redirect(_pc), o_flush  pipeline control
module trap_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [30:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic        inst_valid,
  input  logic [31:0] inst_pc,
  input  logic        ext_irq,
  input  logic        sw_irq,
  input  logic        timer_irq,
  input  logic        o_mstatus_mie,
  input  logic        o_mstatus_mpie,
  input  logic [29:0] o_mtvec_base,
  input  logic [1:0]  o_mtvec_mode,
  input  logic [31:0] o_mepc_value,
  output logic        take_trap,
  output logic        i_mcause_interrupt,
  output logic [30:0] i_mcause_exception_code,
  output logic [31:0] i_mepc_value,
  output logic [31:0] i_mtval_value,
  output logic        i_mstatus_mie,
  output logic        i_mstatus_mpie,
  output logic [1:0]  i_mstatus_mpp,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    RETURN = 2'd2
  } state_t;

  state_t      state;
  logic        trap_pulse;

  logic        ext_s1, ext_s2;
  logic        sw_s1, sw_s2;
  logic        timer_s1, timer_s2;

  logic        shadow_intr;
  logic [30:0] shadow_code;
  logic [31:0] shadow_tval;

  logic        irq_pending;
  logic [30:0] irq_code;
  logic [31:0] tvec_base;
  logic [31:0] irq_offset;
  logic [31:0] irq_target;

  // Two-flop synchronizers; nothing downstream looks at the raw lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_s1   <= 1'b0;
      ext_s2   <= 1'b0;
      sw_s1    <= 1'b0;
      sw_s2    <= 1'b0;
      timer_s1 <= 1'b0;
      timer_s2 <= 1'b0;
    end else begin
      ext_s1   <= ext_irq;
      ext_s2   <= ext_s1;
      sw_s1    <= sw_irq;
      sw_s2    <= sw_s1;
      timer_s1 <= timer_irq;
      timer_s2 <= timer_s1;
    end
  end

  // An interrupt is only taken against a valid retiring instruction, whose
  // PC becomes mepc. When several lines are high, ext wins over sw, and sw
  // wins over timer.
  assign irq_pending = o_mstatus_mie & inst_valid & (ext_s2 | sw_s2 | timer_s2);

  always_comb begin
    irq_code = 31'd7;
    if (ext_s2) begin
      irq_code = 31'd11;
    end else if (sw_s2) begin
      irq_code = 31'd3;
    end
  end

  // Vectored mode only applies to interrupts; modes 2 and 3 fall back to
  // direct. code<<2 is truncated to 32 bits, so code bit 30 drops out.
  assign tvec_base  = {o_mtvec_base, 2'b00};
  assign irq_offset = {irq_code[29:0], 2'b00};
  assign irq_target = (o_mtvec_mode == 2'd1) ? (tvec_base + irq_offset) : tvec_base;

  assign take_trap  = trap_pulse;
  assign o_redirect = trap_pulse;
  assign o_flush    = trap_pulse;

  // The sequencer. A request is accepted only in IDLE. All update values are
  // registered on the accepting edge, so they are valid during the single
  // ENTER/RETURN cycle and are held afterwards. Reset aborts any step in
  // progress because the pulse flop is cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                   <= IDLE;
      trap_pulse              <= 1'b0;
      i_mcause_interrupt      <= 1'b0;
      i_mcause_exception_code <= '0;
      i_mepc_value            <= '0;
      i_mtval_value           <= '0;
      i_mstatus_mie           <= 1'b0;
      i_mstatus_mpie          <= 1'b0;
      i_mstatus_mpp           <= 2'b00;
      o_redirect_pc           <= RESET_PC;
      shadow_intr             <= 1'b0;
      shadow_code             <= '0;
      shadow_tval             <= '0;
    end else begin
      trap_pulse <= 1'b0;
      case (state)
        IDLE: begin
          // An exception always wins. That covers exc_valid together with
          // MRET, and it leaves any interrupt pending for a later cycle.
          if (exc_valid) begin
            state                   <= ENTER;
            trap_pulse              <= 1'b1;
            i_mcause_interrupt      <= 1'b0;
            i_mcause_exception_code <= exc_cause;
            i_mepc_value            <= exc_pc;
            i_mtval_value           <= exc_tval;
            i_mstatus_mpie          <= o_mstatus_mie;
            i_mstatus_mie           <= 1'b0;
            i_mstatus_mpp           <= 2'b11;
            o_redirect_pc           <= tvec_base;
          end else if (irq_pending) begin
            state                   <= ENTER;
            trap_pulse              <= 1'b1;
            i_mcause_interrupt      <= 1'b1;
            i_mcause_exception_code <= irq_code;
            i_mepc_value            <= inst_pc;
            i_mtval_value           <= '0;
            i_mstatus_mpie          <= o_mstatus_mie;
            i_mstatus_mie           <= 1'b0;
            i_mstatus_mpp           <= 2'b11;
            o_redirect_pc           <= irq_target;
          end else if (mret) begin
            // mepc is written back unchanged. mcause/mtval replay the
            // values from the last trap entry, so the write is harmless.
            state                   <= RETURN;
            trap_pulse              <= 1'b1;
            i_mcause_interrupt      <= shadow_intr;
            i_mcause_exception_code <= shadow_code;
            i_mepc_value            <= o_mepc_value;
            i_mtval_value           <= shadow_tval;
            i_mstatus_mie           <= o_mstatus_mpie;
            i_mstatus_mpie          <= 1'b1;
            i_mstatus_mpp           <= 2'b11;
            o_redirect_pc           <= o_mepc_value;
          end
        end
        ENTER: begin
          // Record what this entry wrote, so a later MRET can replay it.
          shadow_intr <= i_mcause_interrupt;
          shadow_code <= i_mcause_exception_code;
          shadow_tval <= i_mtval_value;
          state       <= IDLE;
        end
        RETURN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl -- self-checking bench for trap_ctrl.
//
// A table of single-request vectors (exceptions, MRET, collisions, mtvec
// modes) is followed by hand-written sequences for the multi-cycle cases:
// - synchronized interrupts;
// - a masked interrupt;
// - a request arriving during ENTER;
// - an exception racing an interrupt;
// - reset during ENTER.
// Expected trap records are pushed to a queue when the stimulus is driven.
// Every take_trap pulse seen on the DUT pops one record and compares it.
module tb_trap_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        exc_valid;
  logic [30:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic        ext_irq, sw_irq, timer_irq;
  logic        o_mstatus_mie, o_mstatus_mpie;
  logic [29:0] o_mtvec_base;
  logic [1:0]  o_mtvec_mode;
  logic [31:0] o_mepc_value;
  logic        take_trap;
  logic        i_mcause_interrupt;
  logic [30:0] i_mcause_exception_code;
  logic [31:0] i_mepc_value;
  logic [31:0] i_mtval_value;
  logic        i_mstatus_mie, i_mstatus_mpie;
  logic [1:0]  i_mstatus_mpp;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_flush;

  trap_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .inst_valid(inst_valid), .inst_pc(inst_pc),
    .ext_irq(ext_irq), .sw_irq(sw_irq), .timer_irq(timer_irq),
    .o_mstatus_mie(o_mstatus_mie), .o_mstatus_mpie(o_mstatus_mpie),
    .o_mtvec_base(o_mtvec_base), .o_mtvec_mode(o_mtvec_mode), .o_mepc_value(o_mepc_value),
    .take_trap(take_trap), .i_mcause_interrupt(i_mcause_interrupt),
    .i_mcause_exception_code(i_mcause_exception_code), .i_mepc_value(i_mepc_value),
    .i_mtval_value(i_mtval_value), .i_mstatus_mie(i_mstatus_mie),
    .i_mstatus_mpie(i_mstatus_mpie), .i_mstatus_mpp(i_mstatus_mpp),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_flush(o_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        intr;
    logic [30:0] code;
    logic [31:0] mepc;
    logic [31:0] mtval;
    logic        mie;
    logic        mpie;
    logic [1:0]  mpp;
    logic [31:0] pc;
  } want_t;

  typedef struct {
    string       name;
    logic        exc;
    logic        mret_in;
    logic [30:0] cause;
    logic [31:0] pc;
    logic [31:0] tval;
    logic        mie;
    logic        mpie;
    logic [29:0] base;
    logic [1:0]  mode;
    logic [31:0] mepc;
    logic        expect_trap;
    want_t       want;
  } vec_t;

  vec_t  vecs[8];
  want_t sb[$];
  int    tests = 0;
  int    fails = 0;
  bit    trap_seen;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Runs every cycle. A take_trap pulse must match the oldest queued record.
  task automatic checkOutput();
    want_t w;
    if (take_trap === 1'b1) begin
      trap_seen = 1'b1;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_trap: got take_trap=1 with no trap expected");
      end else begin
        w = sb.pop_front();
        checkVal("redirect", 32'(o_redirect), 32'd1);
        checkVal("flush", 32'(o_flush), 32'd1);
        checkVal("mcause_intr", 32'(i_mcause_interrupt), 32'(w.intr));
        checkVal("mcause_code", 32'(i_mcause_exception_code), 32'(w.code));
        checkVal("mepc", i_mepc_value, w.mepc);
        checkVal("mtval", i_mtval_value, w.mtval);
        checkVal("mstatus_mie", 32'(i_mstatus_mie), 32'(w.mie));
        checkVal("mstatus_mpie", 32'(i_mstatus_mpie), 32'(w.mpie));
        checkVal("mstatus_mpp", 32'(i_mstatus_mpp), 32'(w.mpp));
        checkVal("redirect_pc", o_redirect_pc, w.pc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic waitTrap(input string name, input int max_cycles);
    trap_seen = 1'b0;
    for (int i = 0; i < max_cycles && !trap_seen; i++) tick();
    checkVal(name, 32'(trap_seen), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    exc_valid      = v.exc;
    mret           = v.mret_in;
    exc_cause      = v.cause;
    exc_pc         = v.pc;
    exc_tval       = v.tval;
    o_mstatus_mie  = v.mie;
    o_mstatus_mpie = v.mpie;
    o_mtvec_base   = v.base;
    o_mtvec_mode   = v.mode;
    o_mepc_value   = v.mepc;
    if (v.expect_trap) sb.push_back(v.want);
  endtask

  task automatic idleRetire();
    exc_valid = 1'b0;
    mret      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{name:"idle", exc:0, mret_in:0, cause:31'd0, pc:32'h0, tval:32'h0, mie:1, mpie:0,
                base:30'h2000, mode:2'd0, mepc:32'h0, expect_trap:0,
                want:'{intr:0, code:31'd0, mepc:32'h0, mtval:32'h0, mie:0, mpie:0, mpp:2'd0, pc:32'h0}};
    vecs[1] = '{name:"exc_basic", exc:1, mret_in:0, cause:31'd2, pc:32'h100, tval:32'hDEAD, mie:1, mpie:0,
                base:30'h2000, mode:2'd0, mepc:32'h0, expect_trap:1,
                want:'{intr:0, code:31'd2, mepc:32'h100, mtval:32'hDEAD, mie:0, mpie:1, mpp:2'd3, pc:32'h8000}};
    vecs[2] = '{name:"mret_basic", exc:0, mret_in:1, cause:31'd0, pc:32'h0, tval:32'h0, mie:0, mpie:1,
                base:30'h2000, mode:2'd0, mepc:32'h104, expect_trap:1,
                want:'{intr:0, code:31'd2, mepc:32'h104, mtval:32'hDEAD, mie:1, mpie:1, mpp:2'd3, pc:32'h104}};
    vecs[3] = '{name:"exc_mret", exc:1, mret_in:1, cause:31'd5, pc:32'h300, tval:32'h1234, mie:0, mpie:1,
                base:30'h2000, mode:2'd0, mepc:32'h999, expect_trap:1,
                want:'{intr:0, code:31'd5, mepc:32'h300, mtval:32'h1234, mie:0, mpie:0, mpp:2'd3, pc:32'h8000}};
    vecs[4] = '{name:"exc_vec_mode", exc:1, mret_in:0, cause:31'd13, pc:32'h400, tval:32'h0, mie:1, mpie:0,
                base:30'h2000, mode:2'd1, mepc:32'h0, expect_trap:1,
                want:'{intr:0, code:31'd13, mepc:32'h400, mtval:32'h0, mie:0, mpie:1, mpp:2'd3, pc:32'h8000}};
    vecs[5] = '{name:"mret_mpie0", exc:0, mret_in:1, cause:31'd0, pc:32'h0, tval:32'h0, mie:1, mpie:0,
                base:30'h2000, mode:2'd0, mepc:32'h404, expect_trap:1,
                want:'{intr:0, code:31'd13, mepc:32'h404, mtval:32'h0, mie:0, mpie:1, mpp:2'd3, pc:32'h404}};
    vecs[6] = '{name:"exc_max", exc:1, mret_in:0, cause:31'h7FFF_FFFF, pc:32'hFFFF_FFFC, tval:32'hFFFF_FFFF,
                mie:1, mpie:0, base:30'h3FFF_FFFF, mode:2'd2, mepc:32'h0, expect_trap:1,
                want:'{intr:0, code:31'h7FFF_FFFF, mepc:32'hFFFF_FFFC, mtval:32'hFFFF_FFFF, mie:0, mpie:1,
                       mpp:2'd3, pc:32'hFFFF_FFFC}};
    vecs[7] = '{name:"mret_replay", exc:0, mret_in:1, cause:31'd0, pc:32'h0, tval:32'h0, mie:0, mpie:1,
                base:30'h2000, mode:2'd0, mepc:32'h500, expect_trap:1,
                want:'{intr:0, code:31'h7FFF_FFFF, mepc:32'h500, mtval:32'hFFFF_FFFF, mie:1, mpie:1,
                       mpp:2'd3, pc:32'h500}};

    rst = 1'b0;
    exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0; mret = 1'b0;
    inst_valid = 1'b0; inst_pc = '0; ext_irq = 1'b0; sw_irq = 1'b0; timer_irq = 1'b0;
    o_mstatus_mie = 1'b0; o_mstatus_mpie = 1'b0; o_mtvec_base = 30'h2000; o_mtvec_mode = 2'd0;
    o_mepc_value = '0;
    repeat (3) tick();

    // Reset state
    checkVal("rst_take_trap", 32'(take_trap), 32'd0);
    checkVal("rst_flush", 32'(o_flush), 32'd0);
    checkVal("rst_redirect", 32'(o_redirect), 32'd0);
    checkVal("rst_redirect_pc", o_redirect_pc, RST_PC);
    checkVal("rst_mepc", i_mepc_value, 32'h0);
    checkVal("rst_mtval", i_mtval_value, 32'h0);
    checkVal("rst_code", 32'(i_mcause_exception_code), 32'h0);
    checkVal("rst_mpp", 32'(i_mstatus_mpp), 32'h0);
    rst = 1'b1;
    tick();

    // Table-driven single requests
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkVal({vecs[i].name, "_pulse"}, 32'(take_trap), 32'(vecs[i].expect_trap));
      idleRetire();
      tick();
      checkVal({vecs[i].name, "_drop"}, 32'(take_trap), 32'd0);
      if (vecs[i].expect_trap)
        checkVal({vecs[i].name, "_hold_mepc"}, i_mepc_value, vecs[i].want.mepc);
    end

    // Vectored interrupt through the synchronizers; ext outranks timer
    o_mtvec_base = 30'h2000; o_mtvec_mode = 2'd1; o_mstatus_mie = 1'b1;
    inst_valid = 1'b1; inst_pc = 32'h200; timer_irq = 1'b1; ext_irq = 1'b1;
    sb.push_back('{intr:1, code:31'd11, mepc:32'h200, mtval:32'h0, mie:0, mpie:1, mpp:2'd3, pc:32'h802C});
    tick();
    checkVal("irq_sync1", 32'(take_trap), 32'd0);
    tick();
    checkVal("irq_sync2", 32'(take_trap), 32'd0);
    tick();
    checkVal("irq_enter", 32'(take_trap), 32'd1);
    ext_irq = 1'b0; timer_irq = 1'b0; inst_valid = 1'b0; o_mtvec_mode = 2'd0;
    repeat (3) tick();
    checkVal("irq_after", 32'(take_trap), 32'd0);

    // Masked timer interrupt, then unmasked
    o_mstatus_mie = 1'b0; timer_irq = 1'b1; inst_valid = 1'b1; inst_pc = 32'h600;
    repeat (10) tick();
    checkVal("masked_hold", 32'(take_trap), 32'd0);
    sb.push_back('{intr:1, code:31'd7, mepc:32'h600, mtval:32'h0, mie:0, mpie:1, mpp:2'd3, pc:32'h8000});
    o_mstatus_mie = 1'b1;
    waitTrap("masked_enter", 5);
    timer_irq = 1'b0; inst_valid = 1'b0;
    repeat (3) tick();

    // A second exception during ENTER is ignored
    exc_valid = 1'b1; exc_cause = 31'd1; exc_pc = 32'h800; exc_tval = 32'h11;
    sb.push_back('{intr:0, code:31'd1, mepc:32'h800, mtval:32'h11, mie:0, mpie:1, mpp:2'd3, pc:32'h8000});
    tick();
    exc_cause = 31'd9; exc_pc = 32'h900; exc_tval = 32'h99;
    tick();
    checkVal("enter_ignore", 32'(take_trap), 32'd0);
    checkVal("enter_ignore_hold", i_mepc_value, 32'h800);
    exc_valid = 1'b0;
    tick();
    checkVal("enter_ignore_idle", 32'(take_trap), 32'd0);

    // An exception beats a pending sw interrupt, which is taken next
    sw_irq = 1'b1; inst_valid = 1'b0;
    repeat (2) tick();
    exc_valid = 1'b1; exc_cause = 31'd4; exc_pc = 32'h700; exc_tval = 32'h77;
    inst_valid = 1'b1; inst_pc = 32'h700;
    sb.push_back('{intr:0, code:31'd4, mepc:32'h700, mtval:32'h77, mie:0, mpie:1, mpp:2'd3, pc:32'h8000});
    sb.push_back('{intr:1, code:31'd3, mepc:32'h704, mtval:32'h0, mie:0, mpie:1, mpp:2'd3, pc:32'h8000});
    tick();
    exc_valid = 1'b0; inst_pc = 32'h704;
    waitTrap("irq_after_exc", 4);
    sw_irq = 1'b0; inst_valid = 1'b0;
    repeat (3) tick();

    // Reset asserted during ENTER aborts it
    exc_valid = 1'b1; exc_cause = 31'd6; exc_pc = 32'hA00; exc_tval = 32'h0;
    sb.push_back('{intr:0, code:31'd6, mepc:32'hA00, mtval:32'h0, mie:0, mpie:1, mpp:2'd3, pc:32'h8000});
    tick();
    exc_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkVal("rst_abort_trap", 32'(take_trap), 32'd0);
    checkVal("rst_abort_flush", 32'(o_flush), 32'd0);
    checkVal("rst_abort_pc", o_redirect_pc, RST_PC);
    checkVal("rst_abort_mepc", i_mepc_value, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    checkVal("rst_release", 32'(take_trap), 32'd0);

    checkVal("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
